// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader assembling little-endian words into instruction memory
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
);
  localparam logic [1:0] IDLE = 2'd0, RECV = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(DEPTH);
  logic [1:0]      state;
  logic [1:0]      byte_cnt;
  logic [ADDR_W:0] target, word_cnt, next_cnt, clamped;
  logic [23:0]     asm_buf;
  assign clamped  = num_words > MAX_WORDS ? MAX_WORDS : num_words;
  assign next_cnt = word_cnt + 1'b1;
  assign in_ready = state == RECV;
  assign wr_en    = state == WRITE;
  assign cpu_hold = state == RECV || state == WRITE;
  assign busy     = cpu_hold;
  assign done     = state == DONE;
  assign wr_addr  = word_cnt[ADDR_W-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      word_cnt <= '0;
      target   <= '0;
      asm_buf  <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          target   <= clamped;
          word_cnt <= '0;
          byte_cnt <= '0;
          state    <= clamped == '0 ? DONE : RECV;
        end
        RECV: if (in_valid) begin
          // bytes shift in from the top so byte 0 ends up least significant
          asm_buf  <= {in_data, asm_buf[23:8]};
          byte_cnt <= byte_cnt + 1'b1;
          if (byte_cnt == 2'd3) begin
            wr_data <= {in_data, asm_buf};
            state   <= WRITE;
          end
        end
        WRITE: begin
          word_cnt <= next_cnt;
          state    <= next_cnt == target ? DONE : RECV;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: vector table plus multi-cycle load sequences for imem_loader
module tb_imem_loader;
  logic        clk = 0, rst = 0, start = 0, in_valid = 0;
  logic [5:0]  num_words = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, wr_en, cpu_hold, busy, done;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  int total = 0, bad = 0;
  logic [7:0]  stream [130];
  logic [4:0]  wa [64];
  logic [31:0] wd [64];
  int nwr, hold_bad, ready_bad;
  imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst, start; logic [5:0] nw; logic v; logic [7:0] d;
    logic rdy, we; logic [4:0] a; logic [31:0] wd; logic hold, done;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(logic r, logic s, logic [5:0] n, logic v, logic [7:0] d,
                              logic rdy, logic we, logic [4:0] a, logic [31:0] w, logic h, logic dn);
    vec_t t;
    t.rst = r; t.start = s; t.nw = n; t.v = v; t.d = d;
    t.rdy = rdy; t.we = we; t.a = a; t.wd = w; t.hold = h; t.done = dn;
    return t;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] word_of(int i);
    return {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
  endfunction
  task automatic load(input int nw, input int nb, input bit gappy, input int max_cyc,
                      output int consumed, output bit got_done);
    int idx;
    bit acc;
    idx = 0; got_done = 0; nwr = 0; hold_bad = 0; ready_bad = 0;
    start = 1; num_words = nw[5:0];
    @(posedge clk); #1;
    start = 0;
    if (done) got_done = 1;
    for (int c = 0; c < max_cyc && !got_done; c++) begin
      in_valid = (idx < nb) && (!gappy || wr_en || $urandom_range(0, 1) == 1);
      in_data  = stream[idx < nb ? idx : 0];
      if (wr_en && in_ready) ready_bad++;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (wr_en) begin
        wa[nwr] = wr_addr; wd[nwr] = wr_data; nwr++;
      end
      if (done) got_done = 1;
      else if (!cpu_hold || !busy) hold_bad++;
    end
    if (got_done)
      for (int c = 0; c < 3; c++) begin
        in_valid = idx < nb;
        in_data  = stream[idx < nb ? idx : 0];
        @(posedge clk); #1;
        if (in_ready || cpu_hold || wr_en) ready_bad++;
      end
    in_valid = 0;
    consumed = idx;
  endtask
  initial begin
    logic [7:0] prog [12];
    int consumed;
    bit got_done;
    prog = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00};
    tv.push_back(mk(1, 1, 3, 1, 8'h55, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 3, 1, 8'h66, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h77, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 3, 0, 8'h00, 1, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 3, 1, 8'h93, 1, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h50, 1, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 0, 1, 0, 32'h00500093, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h13, 1, 0, 0, 32'h00500093, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h13, 1, 0, 0, 32'h00500093, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h01, 1, 0, 0, 32'h00500093, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h10, 1, 0, 0, 32'h00500093, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 0, 1, 1, 32'h00100113, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'hB3, 1, 0, 0, 32'h00100113, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'hB3, 1, 0, 0, 32'h00100113, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h81, 1, 0, 0, 32'h00100113, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h20, 1, 0, 0, 32'h00100113, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 0, 1, 2, 32'h002081B3, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 32'h002081B3, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 32'h002081B3, 0, 0));
    tv.push_back(mk(0, 1, 0, 1, 8'hAA, 0, 0, 0, 32'h002081B3, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 0, 32'h002081B3, 0, 0));
    foreach (tv[i]) begin
      rst = tv[i].rst; start = tv[i].start; num_words = tv[i].nw;
      in_valid = tv[i].v; in_data = tv[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d ctl{rdy,we,hold,busy,done}", i),
          {27'd0, in_ready, wr_en, cpu_hold, busy, done},
          {27'd0, tv[i].rdy, tv[i].we, tv[i].hold, tv[i].hold, tv[i].done});
      chk($sformatf("vec%0d wr_data", i), wr_data, tv[i].wd);
      if (tv[i].we) chk($sformatf("vec%0d wr_addr", i), {27'd0, wr_addr}, {27'd0, tv[i].a});
    end
    rst = 0; start = 0; in_valid = 0;
    foreach (prog[i]) stream[i] = prog[i];
    load(3, 12, 1, 200, consumed, got_done);
    chk("gappy done", {31'd0, got_done}, 1);
    chk("gappy writes", nwr, 3);
    chk("gappy consumed", consumed, 12);
    chk("gappy hold", hold_bad, 0);
    chk("gappy ready in write", ready_bad, 0);
    for (int i = 0; i < 3 && i < nwr; i++) begin
      chk($sformatf("gappy addr%0d", i), {27'd0, wa[i]}, i);
      chk($sformatf("gappy data%0d", i), wd[i], word_of(i));
    end
    for (int i = 0; i < 130; i++) stream[i] = 8'(i * 37 + 11);
    load(40, 130, 0, 400, consumed, got_done);
    chk("clamp done", {31'd0, got_done}, 1);
    chk("clamp writes", nwr, 32);
    chk("clamp consumed", consumed, 128);
    chk("clamp hold", hold_bad, 0);
    chk("clamp ready after done", ready_bad, 0);
    for (int i = 0; i < 32 && i < nwr; i++) begin
      chk($sformatf("clamp addr%0d", i), {27'd0, wa[i]}, i);
      chk($sformatf("clamp data%0d", i), wd[i], word_of(i));
    end
    foreach (prog[i]) stream[i] = prog[i];
    load(2, 6, 0, 20, consumed, got_done);
    chk("midrst no done", {31'd0, got_done}, 0);
    chk("midrst writes", nwr, 1);
    chk("midrst data0", wd[0], 32'h00500093);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst idle", {27'd0, in_ready, wr_en, cpu_hold, busy, done}, 0);
    stream[0] = 8'hDE; stream[1] = 8'hAD; stream[2] = 8'hBE; stream[3] = 8'hEF;
    load(1, 4, 0, 20, consumed, got_done);
    chk("restart done", {31'd0, got_done}, 1);
    chk("restart writes", nwr, 1);
    chk("restart addr", {27'd0, wa[0]}, 0);
    chk("restart data", wd[0], 32'hEFBEADDE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes machine code into the CPU's 32-word instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each completed word is issued as a single-cycle write to the instruction memory write port. While a load session is active it holds the CPU via `cpu_hold`, and it pulses `done` when the program is in place.

## Interface

Parameters:
- `DEPTH`, 32, instruction memory depth in words.
- `ADDR_W`, 5, word-address width; log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load session; sampled only in IDLE.
- `num_words`  in  `ADDR_W`+1  words to load; sampled on `start`.
- `in_valid`  in  1  byte source has `in_data` valid.
- `in_data`  in  8  program byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `wr_en`  out  1  instruction memory write strobe, one cycle per word.
- `wr_addr`  out  `ADDR_W`  word index being written.
- `wr_data`  out  32  assembled instruction word.
- `cpu_hold`  out  1  CPU must stall and keep PC at 0 while high.
- `busy`  out  1  session in progress.
- `done`  out  1  one-cycle pulse at session end.

## Operation

- State machine: IDLE, RECV, WRITE, DONE.
- IDLE:
  - `in_ready`=0, `cpu_hold`=0, `busy`=0.
  - On `start`: latch the target count. If `num_words` > `DEPTH`, the target is clamped to `DEPTH`.
  - Target 0 → DONE. Otherwise clear `word_cnt` and `byte_cnt` and go to RECV.
- RECV:
  - `in_ready`=1, `cpu_hold`=1, `busy`=1.
  - A byte is accepted on an edge where `in_valid` and `in_ready` are both high.
  - Byte k (k=0..3) of the current word goes into bits [8k+7:8k]. Byte 0 is the least significant byte.
  - `byte_cnt` wraps 3→0. The accept that completes byte 3 moves the FSM to WRITE.
- WRITE, exactly one cycle:
  - `wr_en`=1, `wr_addr`=`word_cnt`, `wr_data`=assembled word. `in_ready`=0.
  - Next edge: `word_cnt`++. If the new count equals the target → DONE, else → RECV.
- DONE, one cycle: `done`=1, `cpu_hold`=0, `busy`=0, then → IDLE.
- `start` is ignored outside IDLE.
- In-flight `in_valid` is never consumed outside RECV.
- No checksum and no timeout: a stalled source leaves the loader in RECV indefinitely, with `cpu_hold` held high.
- `wr_addr` never exceeds `DEPTH`-1 because of the clamp.
- `wr_data` holds its last value when `wr_en`=0. The memory must qualify writes with `wr_en` only.

## Timing

- Reset values, taken at the first edge with `rst`=1:
  - state IDLE; `word_cnt`=0, `byte_cnt`=0.
  - `in_ready`, `wr_en`, `cpu_hold`, `busy`, `done` all 0.
  - `wr_addr`=0, `wr_data`=0.
- Outputs are decoded from registered state or driven from registers; no combinational path from `in_valid` or `start` to any output.
- `start` at edge S:
  - Non-zero target: RECV from S, so `in_ready`=1 and `cpu_hold`=1 in the cycle after S.
  - Zero target: `done`=1 in the cycle after S, with no `wr_en`.
- 4th byte of a word accepted at edge N:
  - `wr_en`=1 in cycle N..N+1, and the memory samples it at edge N+1.
  - `in_ready` returns at N+1 if more words remain.
- Maximum throughput: 4 bytes per 5 cycles (4 RECV cycles plus 1 WRITE cycle).
- Last word's write cycle is followed by the DONE cycle: `done` is high, and `cpu_hold` falls one cycle after the final `wr_en`.
- `rst` mid-session:
  - Next edge forces IDLE and discards the partial word.
  - No `wr_en` is issued for incomplete words.
  - Words already written stay in memory.
- `rst` and `start` together: reset wins.

## Test plan

- Reset: hold `rst` for 2 cycles with random inputs → all outputs 0 and `in_ready`=0. `start` asserted during reset is ignored.
- Back-to-back load:
  - Stimulus: `num_words`=3, bytes 93 00 50 00 13 01 10 00 B3 81 20 00 presented back-to-back.
  - Required: writes (addr 0, 0x00500093), (1, 0x00100113), (2, 0x002081B3), each with a one-cycle `wr_en`.
  - Required: `done` pulses on the cycle after the third write; `cpu_hold` is high from the cycle after `start` until `done`.
- Gappy source:
  - Stimulus: same stream with `in_valid` toggled pseudo-randomly, and a byte offered during every WRITE cycle.
  - Required: identical writes. `in_ready`=0 during WRITE, so the offered byte is not consumed until the next RECV cycle.
- Zero words: `num_words`=0 → `done` pulses one cycle after `start`, with no `wr_en` and no `in_ready`.
- Clamp: `num_words`=40, 130 bytes offered → 32 writes (last `wr_addr`=31), exactly 128 bytes consumed, `in_ready` never high after DONE.
- Reset mid-word:
  - Stimulus: assert `rst` after 2 bytes of word 1 (word 0 already written), then restart with 1 word DE AD BE EF.
  - Required: no write for the partial word. After restart, exactly one write (addr 0, 0xEFBEADDE).
